steer_merge4: RTL and testbench



---
 rtl/steer_merge4_pkg.sv | 20 ++
 rtl/steer_merge4_rr_arb4.sv | 37 +++
 rtl/steer_merge4.sv | 133 +++++++++++++
 tb/tb_steer_merge4.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/steer_merge4_pkg.sv
// Shared dual-rail encodings, FSM state type and validity helper for steer_merge4.
package steer_pkg;

    localparam logic [1:0] DR_NULL    = 2'b00;
    localparam logic [1:0] DR_DATA0   = 2'b01;
    localparam logic [1:0] DR_DATA1   = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_NULL = 2'd0,
        S_DATA = 2'd1,
        S_RTN  = 2'd2
    } state_t;

    // Only the two single-rail-high codes carry data; NULL and 11 do not.
    function automatic logic dr_valid(input logic [1:0] dr);
        return (dr == DR_DATA0) || (dr == DR_DATA1);
    endfunction

endpackage

// File: rtl/steer_merge4_rr_arb4.sv
// Combinational 4-way round-robin arbiter: first request at or after ptr wins.
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx
);

    logic [3:0] rot;
    logic       found;
    logic [1:0] off;

    // rot[k] is the request k positions after the pointer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            localparam logic [1:0] OFS = 2'(gi);
            logic [1:0] sel;
            assign sel     = ptr + OFS;
            assign rot[gi] = req[sel];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        off   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = 2'(k);
            end
        end
    end

    assign idx = ptr + off;
    assign gnt = found ? (4'b0001 << idx) : 4'b0000;

endmodule

// File: rtl/steer_merge4.sv
// 4-way NCL dual-rail merge with round-robin arbitration and one-hot source tag.
// Optional protocol checking is enabled by defining STEER_MERGE_ERRCHK_EN.
module steer_merge4
    import steer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Ss,
    input  logic [1:0] Ts,
    input  logic [1:0] Us,
    input  logic [1:0] Vs,
    input  logic       ki,
    output logic [1:0] A,
    output logic [3:0] tagout,
    output logic [3:0] ko,
    output logic [3:0] err
);

    state_t     state_reg, state_next;
    logic [1:0] a_reg, a_next;
    logic [3:0] tag_reg, tag_next;
    logic [3:0] ko_reg, ko_next;
    logic [1:0] ptr_reg, ptr_next;
    logic [1:0] gidx_reg, gidx_next;

    logic [1:0] ch [4];
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;

    assign ch[0] = Ss;
    assign ch[1] = Ts;
    assign ch[2] = Us;
    assign ch[3] = Vs;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_req
            assign req[gi] = dr_valid(ch[gi]);
        end
    endgenerate

    rr_arb4 u_arb (
        .req (req),
        .ptr (ptr_reg),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_NULL;
            a_reg     <= DR_NULL;
            tag_reg   <= 4'b0000;
            ko_reg    <= 4'b1111;
            ptr_reg   <= 2'd0;
            gidx_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            tag_reg   <= tag_next;
            ko_reg    <= ko_next;
            ptr_reg   <= ptr_next;
            gidx_reg  <= gidx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        tag_next   = tag_reg;
        ko_next    = ko_reg;
        ptr_next   = ptr_reg;
        gidx_next  = gidx_reg;
        case (state_reg)
            S_NULL: begin
                if (ki && (|req)) begin
                    a_next     = ch[gnt_idx];
                    tag_next   = gnt;
                    ko_next    = ~gnt;
                    gidx_next  = gnt_idx;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (!ki) begin
                    a_next     = DR_NULL;
                    tag_next   = 4'b0000;
                    state_next = S_RTN;
                end
            end
            S_RTN: begin
                // Release only once the source has withdrawn to NULL and the sink wants data.
                if (ki && (ch[gidx_reg] == DR_NULL)) begin
                    ko_next    = 4'b1111;
                    ptr_next   = gidx_reg + 2'd1;
                    state_next = S_NULL;
                end
            end
            default: state_next = S_NULL;
        endcase
    end

    assign A      = a_reg;
    assign tagout = tag_reg;
    assign ko     = ko_reg;

`ifdef STEER_MERGE_ERRCHK_EN
    logic [3:0] err_reg;
    logic [3:0] err_hit;

    // In S_DATA, A still holds the value latched from the granted channel.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_err
            assign err_hit[gi] = (ch[gi] == DR_ILLEGAL) ||
                                 ((state_reg == S_DATA) && tag_reg[gi] &&
                                  (ch[gi] != DR_NULL) && (ch[gi] != a_reg));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 4'b0000;
        end else begin
            err_reg <= err_reg | err_hit;
        end
    end

    assign err = err_reg;
`else
    assign err = 4'b0000;
`endif

endmodule

// File: tb/tb_steer_merge4.sv
// Directed bench for steer_merge4: reference model checked every cycle plus literal checks.
module tb_steer_merge4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] Ss = 2'b00, Ts = 2'b00, Us = 2'b00, Vs = 2'b00;
    logic       ki = 1'b1;
    logic [1:0] A;
    logic [3:0] tagout, ko, err;

    int n_cmp = 0;
    int n_bad = 0;

    steer_merge4 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Ss     (Ss),
        .Ts     (Ts),
        .Us     (Us),
        .Vs     (Vs),
        .ki     (ki),
        .A      (A),
        .tagout (tagout),
        .ko     (ko),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = waiting for a winner, 1 = value on output, 2 = returning to NULL.
    int         m_phase, m_ptr, m_who;
    logic [1:0] m_held;
    logic [1:0] m_a;
    logic [3:0] m_tag, m_ko, m_err;

    always @(posedge clk or negedge rst_n) begin : model
        logic [1:0] v [4];
        bit         taken;
        int         c;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_who = 0; m_held = 2'b00;
            m_a = 2'b00; m_tag = 4'b0000; m_ko = 4'b1111; m_err = 4'b0000;
        end else begin
            v[0] = Ss; v[1] = Ts; v[2] = Us; v[3] = Vs;
`ifdef STEER_MERGE_ERRCHK_EN
            for (int i = 0; i < 4; i++) begin
                if (v[i] == 2'b11) m_err[i] = 1'b1;
                if (m_phase == 1 && i == m_who && v[i] != 2'b00 && v[i] != m_held)
                    m_err[i] = 1'b1;
            end
`endif
            case (m_phase)
                0: if (ki) begin
                    taken = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        c = (m_ptr + k) % 4;
                        if (!taken && (v[c] == 2'b01 || v[c] == 2'b10)) begin
                            taken   = 1'b1;
                            m_who   = c;
                            m_held  = v[c];
                            m_a     = v[c];
                            m_tag   = 4'(1 << c);
                            m_ko    = 4'b1111 & ~4'(1 << c);
                            m_phase = 1;
                        end
                    end
                end
                1: if (!ki) begin
                    m_a = 2'b00; m_tag = 4'b0000; m_phase = 2;
                end
                default: if (ki && v[m_who] == 2'b00) begin
                    m_ko = 4'b1111; m_ptr = (m_who + 1) % 4; m_phase = 0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        n_cmp++;
        if ({A, tagout, ko, err} !== {m_a, m_tag, m_ko, m_err}) begin
            n_bad++;
            $display("FAIL model t=%0t: A=%b tag=%b ko=%b err=%b, required A=%b tag=%b ko=%b err=%b",
                     $time, A, tagout, ko, err, m_a, m_tag, m_ko, m_err);
        end
    end

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got A/tag/ko/err=%b required %b", name, got, exp);
        end else begin
            $display("ok   %s: A/tag/ko/err=%b", name, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

`ifdef STEER_MERGE_ERRCHK_EN
    localparam logic [3:0] ERR_U  = 4'b0100;
    localparam logic [3:0] ERR_SU = 4'b0101;
`else
    localparam logic [3:0] ERR_U  = 4'b0000;
    localparam logic [3:0] ERR_SU = 4'b0000;
`endif

    initial begin
        tick(2);
        check("reset", {A, tagout, ko, err}, {2'b00, 4'b0000, 4'b1111, 4'b0000});
        rst_n = 1'b1;

        // Single transfer on T.
        Ts = 2'b10; ki = 1'b1; tick(1);
        check("t_grant", {A, tagout, ko, err}, {2'b10, 4'b0010, 4'b1101, 4'b0000});
        ki = 1'b0; tick(1);
        check("t_null", {A, tagout, ko, err}, {2'b00, 4'b0000, 4'b1101, 4'b0000});
        Ts = 2'b00; ki = 1'b1; tick(1);
        check("t_release", {A, tagout, ko, err}, {2'b00, 4'b0000, 4'b1111, 4'b0000});

        // S and V simultaneous from pointer 0.
        do_reset();
        Ss = 2'b01; Vs = 2'b10; tick(1);
        check("sv_s_first", {A, tagout, ko, err}, {2'b01, 4'b0001, 4'b1110, 4'b0000});
        ki = 1'b0; tick(1);
        Ss = 2'b00; ki = 1'b1; tick(1);
        check("sv_s_done", {A, tagout, ko, err}, {2'b00, 4'b0000, 4'b1111, 4'b0000});
        tick(1);
        check("sv_v_second", {A, tagout, ko, err}, {2'b10, 4'b1000, 4'b0111, 4'b0000});
        ki = 1'b0; tick(1);
        Vs = 2'b00; ki = 1'b1; tick(1);

        // Pointer now 0: S beats U, pointer moves to 1.
        Ss = 2'b10; Us = 2'b01; tick(1);
        check("su_s_first", {A, tagout, ko, err}, {2'b10, 4'b0001, 4'b1110, 4'b0000});
        ki = 1'b0; tick(1);
        Ss = 2'b00; ki = 1'b1; tick(2);
        check("su_u_second", {A, tagout, ko, err}, {2'b01, 4'b0100, 4'b1011, 4'b0000});
        ki = 1'b0; tick(1);
        Us = 2'b00; ki = 1'b1; tick(1);

        // Pointer now 3: S wraps ahead of T.
        Ss = 2'b01; Ts = 2'b01; tick(1);
        check("wrap_s", {A, tagout, ko, err}, {2'b01, 4'b0001, 4'b1110, 4'b0000});
        ki = 1'b0; tick(1);
        Ss = 2'b00; ki = 1'b1; tick(2);
        check("wrap_t_next", {A, tagout, ko, err}, {2'b01, 4'b0010, 4'b1101, 4'b0000});
        ki = 1'b0; tick(1);
        Ts = 2'b00; ki = 1'b1; tick(1);

        // No grant while ki is low in S_NULL.
        ki = 1'b0; Us = 2'b01; tick(3);
        check("ki_low_hold", {A, tagout, ko, err}, {2'b00, 4'b0000, 4'b1111, 4'b0000});
        ki = 1'b1; tick(1);
        check("ki_high_grant", {A, tagout, ko, err}, {2'b01, 4'b0100, 4'b1011, 4'b0000});

        // Asynchronous reset in the middle of S_DATA.
        #1 rst_n = 1'b0;
        #1 check("async_reset", {A, tagout, ko, err}, {2'b00, 4'b0000, 4'b1111, 4'b0000});
        Us = 2'b00;
        tick(1);
        rst_n = 1'b1;

        // Illegal code on U is flagged and never granted.
        Us = 2'b11; tick(3);
        check("illegal_u", {A, tagout, ko, err}, {2'b00, 4'b0000, 4'b1111, ERR_U});
        Ss = 2'b01; tick(1);
        check("illegal_s_win", {A, tagout, ko, err}, {2'b01, 4'b0001, 4'b1110, ERR_U});
        // Granted channel changing its data during S_DATA.
        Ss = 2'b10; tick(1);
        check("change_in_data", {A, tagout, ko, err}, {2'b01, 4'b0001, 4'b1110, ERR_SU});
        ki = 1'b0; Ss = 2'b00; Us = 2'b00; tick(1);
        ki = 1'b1; tick(2);
        check("err_sticky", {A, tagout, ko, err}, {2'b00, 4'b0000, 4'b1111, ERR_SU});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
